// File: rtl/lm_sm_if.sv
// Decode/pipeline-facing bundle for the LM/SM micro-op sequencer.
// master = decode/pipeline side, slave = sequencer.
interface lm_sm_if;
  logic [15:0] dec_ir;
  logic        dec_valid;
  logic        stall_in;
  logic        busy;
  logic        hold_front;
  logic        uop_valid;
  logic [2:0]  uop_reg;
  logic [15:0] uop_offset;
  logic [2:0]  uop_base;
  logic        uop_is_store;
  logic        uop_last;
  logic        uop_wb;

  modport master (
    output dec_ir, dec_valid, stall_in,
    input  busy, hold_front, uop_valid, uop_reg, uop_offset, uop_base,
           uop_is_store, uop_last, uop_wb
  );

  modport slave (
    input  dec_ir, dec_valid, stall_in,
    output busy, hold_front, uop_valid, uop_reg, uop_offset, uop_base,
           uop_is_store, uop_last, uop_wb
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Expands LM/SM in decode into one memory micro-op per set register-list bit.
// Define LMSM_BASE_WB_EN to append a base-register writeback micro-op (Ra <= Ra + N).
module lm_sm_sequencer (
  input  logic    clk,
  input  logic    reset,
  lm_sm_if.slave  bus
);

`ifdef LMSM_BASE_WB_EN
  localparam bit WbEn = 1'b1;
`else
  localparam bit WbEn = 1'b0;
`endif

  localparam logic [3:0] OpLm = 4'b0110;
  localparam logic [3:0] OpSm = 4'b0111;

  typedef enum logic [1:0] {StIdle, StSeq, StWb} state_e;

  state_e      state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic [3:0]  count_q, count_d;
  logic [2:0]  base_q, base_d;
  logic        store_q, store_d;

  logic        is_lmsm, accept, valid, in_wb, last, one_left;
  logic [7:0]  mask_rest;
  logic [2:0]  low_idx;

  always_comb begin
    is_lmsm   = (bus.dec_ir[15:12] == OpLm) || (bus.dec_ir[15:12] == OpSm);
    accept    = (state_q == StIdle) && bus.dec_valid && is_lmsm &&
                (bus.dec_ir[7:0] != 8'h00) && !bus.stall_in;
    valid     = (state_q != StIdle);
    in_wb     = WbEn && (state_q == StWb);
    // Clearing the lowest set bit leaves the remaining registers to transfer.
    mask_rest = mask_q & (mask_q - 8'd1);
    one_left  = (mask_q != 8'h00) && (mask_rest == 8'h00);
    last      = in_wb || ((state_q == StSeq) && one_left && !WbEn);

    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    bus.busy         = valid;
    bus.uop_valid    = valid;
    bus.uop_reg      = in_wb ? base_q : low_idx;
    bus.uop_offset   = valid ? {12'b0, count_q} : 16'h0000;
    bus.uop_base     = base_q;
    bus.uop_is_store = store_q;
    bus.uop_last     = last;
    bus.uop_wb       = in_wb;
    bus.hold_front   = accept || (valid && !(last && !bus.stall_in));
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    base_d  = base_q;
    store_d = store_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mask_d  = bus.dec_ir[7:0];
          base_d  = bus.dec_ir[11:9];
          store_d = bus.dec_ir[12];
          count_d = 4'd0;
          state_d = StSeq;
        end
      end
      StSeq: begin
        if (!bus.stall_in) begin
          mask_d  = mask_rest;
          count_d = count_q + 4'd1;
          if (one_left) state_d = WbEn ? StWb : StIdle;
        end
      end
      StWb: begin
        if (!bus.stall_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mask_q  <= 8'h00;
      count_q <= 4'd0;
      base_q  <= 3'd0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      base_q  <= base_d;
      store_q <= store_d;
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer; expectations follow LMSM_BASE_WB_EN when defined.
module tb_lm_sm_sequencer;

`ifdef LMSM_BASE_WB_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  lm_sm_if bus ();

  lm_sm_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic uop(input string t, input logic [2:0] r, input logic [15:0] off,
                     input logic last, input logic hold);
    check({t, ".valid"}, 32'(bus.uop_valid), 32'd1);
    check({t, ".busy"},  32'(bus.busy), 32'd1);
    check({t, ".reg"},   32'(bus.uop_reg), 32'(r));
    check({t, ".off"},   32'(bus.uop_offset), 32'(off));
    check({t, ".last"},  32'(bus.uop_last), 32'(last));
    check({t, ".hold"},  32'(bus.hold_front), 32'(hold));
    check({t, ".wb"},    32'(bus.uop_wb), 32'd0);
  endtask

  task automatic idle(input string t);
    check({t, ".valid"}, 32'(bus.uop_valid), 32'd0);
    check({t, ".busy"},  32'(bus.busy), 32'd0);
    check({t, ".hold"},  32'(bus.hold_front), 32'd0);
    check({t, ".last"},  32'(bus.uop_last), 32'd0);
    check({t, ".wb"},    32'(bus.uop_wb), 32'd0);
    check({t, ".reg"},   32'(bus.uop_reg), 32'd0);
    check({t, ".off"},   32'(bus.uop_offset), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.dec_ir    = 16'h0000;
    bus.dec_valid = 1'b0;
    bus.stall_in  = 1'b0;
    tick();
    tick();
    idle("rst");
    check("rst.base",  32'(bus.uop_base), 32'd0);
    check("rst.store", 32'(bus.uop_is_store), 32'd0);
    reset = 1'b0;
    tick();

    // LM Ra=R3, mask 0x05
    bus.dec_ir = 16'h6605; bus.dec_valid = 1'b1; #1;
    check("t1.acc.hold", 32'(bus.hold_front), 32'd1);
    check("t1.acc.valid", 32'(bus.uop_valid), 32'd0);
    tick(); bus.dec_valid = 1'b0; #1;
    uop("t1.u0", 3'd0, 16'd0, 1'b0, 1'b1);
    check("t1.u0.store", 32'(bus.uop_is_store), 32'd0);
    check("t1.u0.base",  32'(bus.uop_base), 32'd3);
    tick();
    uop("t1.u1", 3'd2, 16'd1, !WB, WB);
    check("t1.u1.store", 32'(bus.uop_is_store), 32'd0);
    check("t1.u1.base",  32'(bus.uop_base), 32'd3);
`ifdef LMSM_BASE_WB_EN
    tick();
    check("t1.wb.wb",   32'(bus.uop_wb), 32'd1);
    check("t1.wb.reg",  32'(bus.uop_reg), 32'd3);
    check("t1.wb.off",  32'(bus.uop_offset), 32'd2);
    check("t1.wb.last", 32'(bus.uop_last), 32'd1);
    check("t1.wb.hold", 32'(bus.hold_front), 32'd0);
`endif
    tick();
    idle("t1.end");

    // SM, full mask
    bus.dec_ir = 16'h70FF; bus.dec_valid = 1'b1; #1;
    check("t2.acc.hold", 32'(bus.hold_front), 32'd1);
    tick(); bus.dec_valid = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      uop($sformatf("t2.u%0d", i), 3'(i), 16'(i), (i == 7) && !WB, (i < 7) || WB);
      check($sformatf("t2.u%0d.store", i), 32'(bus.uop_is_store), 32'd1);
    end
`ifdef LMSM_BASE_WB_EN
    tick();
    check("t2.wb.wb",  32'(bus.uop_wb), 32'd1);
    check("t2.wb.off", 32'(bus.uop_offset), 32'd8);
    check("t2.wb.reg", 32'(bus.uop_reg), 32'd0);
`endif
    tick();
    idle("t2.end");

    // LM mask 0x0A, two stall cycles on the first micro-op
    bus.dec_ir = 16'h600A; bus.dec_valid = 1'b1;
    tick(); bus.dec_valid = 1'b0; bus.stall_in = 1'b1; #1;
    uop("t3.s0", 3'd1, 16'd0, 1'b0, 1'b1);
    tick();
    uop("t3.s1", 3'd1, 16'd0, 1'b0, 1'b1);
    tick(); bus.stall_in = 1'b0; #1;
    uop("t3.s2", 3'd1, 16'd0, 1'b0, 1'b1);
    tick();
    uop("t3.u1", 3'd3, 16'd1, !WB, WB);
`ifdef LMSM_BASE_WB_EN
    tick();
    check("t3.wb.off", 32'(bus.uop_offset), 32'd2);
`endif
    tick();
    idle("t3.end");

    // Empty list and non-valid decode are ignored; stall blocks accept
    bus.dec_ir = 16'h6000; bus.dec_valid = 1'b1; #1;
    check("t4.empty.hold", 32'(bus.hold_front), 32'd0);
    tick();
    idle("t4.empty");
    bus.dec_ir = 16'h6605; bus.dec_valid = 1'b0; #1;
    check("t4.novalid.hold", 32'(bus.hold_front), 32'd0);
    tick();
    idle("t4.novalid");
    bus.dec_valid = 1'b1; bus.stall_in = 1'b1; #1;
    check("t4.stall.hold", 32'(bus.hold_front), 32'd0);
    tick();
    idle("t4.stall");
    bus.dec_valid = 1'b0; bus.stall_in = 1'b0;

    // SM mask 0xF0, reset during the 2nd micro-op
    bus.dec_ir = 16'h70F0; bus.dec_valid = 1'b1;
    tick(); bus.dec_valid = 1'b0; #1;
    uop("t5.u0", 3'd4, 16'd0, 1'b0, 1'b1);
    tick();
    uop("t5.u1", 3'd5, 16'd1, 1'b0, 1'b1);
    reset = 1'b1;
    tick(); reset = 1'b0; #1;
    idle("t5.rst");
    check("t5.rst.store", 32'(bus.uop_is_store), 32'd0);
    check("t5.rst.base",  32'(bus.uop_base), 32'd0);
    bus.dec_ir = 16'h6201; bus.dec_valid = 1'b1;
    tick(); bus.dec_valid = 1'b0; #1;
    uop("t5.lm", 3'd0, 16'd0, !WB, WB);
    check("t5.lm.base",  32'(bus.uop_base), 32'd1);
    check("t5.lm.store", 32'(bus.uop_is_store), 32'd0);
    tick();
`ifdef LMSM_BASE_WB_EN
    tick();
`endif
    idle("t5.end");

    // Reset and accept in the same cycle: reset wins
    bus.dec_ir = 16'h6605; bus.dec_valid = 1'b1; reset = 1'b1;
    tick(); reset = 1'b0; bus.dec_valid = 1'b0; #1;
    idle("t6.rstacc");

`ifdef LMSM_BASE_WB_EN
    // LM Ra=R5, mask 0x05 with base writeback
    bus.dec_ir = 16'h6A05; bus.dec_valid = 1'b1;
    tick(); bus.dec_valid = 1'b0; #1;
    uop("t7.u0", 3'd0, 16'd0, 1'b0, 1'b1);
    tick();
    uop("t7.u1", 3'd2, 16'd1, 1'b0, 1'b1);
    tick();
    check("t7.wb.wb",   32'(bus.uop_wb), 32'd1);
    check("t7.wb.reg",  32'(bus.uop_reg), 32'd5);
    check("t7.wb.off",  32'(bus.uop_offset), 32'd2);
    check("t7.wb.last", 32'(bus.uop_last), 32'd1);
    tick();
    idle("t7.end");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
